// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit common-anode seven-segment display.
// Shares one external BCD decoder across all digits and registers the returned pattern.
module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int ON_CYCLES  = 1000,
  parameter int GAP_CYCLES = 16,
  localparam int AW = $clog2(NUM_DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [3:0]            wr_data,
  input  logic [NUM_DIGITS-1:0] blank_mask,
  input  logic                  lzs,
  input  logic [6:0]            seg_in,
  output logic [3:0]            dec_inp,
  output logic [6:0]            seg_out,
  output logic [NUM_DIGITS-1:0] an_n,
  output logic                  frame_done
);

  localparam int CMAX = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(CMAX) + 1;

  typedef enum logic {S_GAP, S_ON} state_t;

  state_t                state;
  logic [AW-1:0]         idx;
  logic [CW-1:0]         cnt;
  logic [3:0]            digit [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] dark;
  logic                  all_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) digit[i] <= '0;
    end else if (wr_en && (int'(wr_addr) < NUM_DIGITS)) begin
      digit[wr_addr] <= wr_data;
    end
  end

  assign dec_inp = digit[idx];

  // Walk from the most significant digit down; a digit is a leading zero while
  // every digit at and above it is zero. Digit 0 is exempt.
  always_comb begin
    all_zero = 1'b1;
    dark     = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      all_zero = all_zero & (digit[NUM_DIGITS-1-i] == 4'd0);
      dark[NUM_DIGITS-1-i] = blank_mask[NUM_DIGITS-1-i]
                           | (lzs & all_zero & (i != NUM_DIGITS-1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_GAP;
      idx        <= '0;
      cnt        <= '0;
      an_n       <= '1;
      seg_out    <= '0;
      frame_done <= 1'b0;
    end else if (!en) begin
      state      <= S_GAP;
      idx        <= '0;
      cnt        <= '0;
      an_n       <= '1;
      seg_out    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (state == S_ON && !dark[idx]) begin
        an_n    <= ~(NUM_DIGITS'(1) << idx);
        seg_out <= seg_in;
      end else begin
        an_n    <= '1;
        seg_out <= '0;
      end
      case (state)
        S_GAP: begin
          if (cnt == CW'(GAP_CYCLES - 1)) begin
            cnt   <= '0;
            state <= S_ON;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_ON: begin
          if (cnt == CW'(ON_CYCLES - 1)) begin
            cnt        <= '0;
            state      <= S_GAP;
            idx        <= (idx == AW'(NUM_DIGITS - 1)) ? '0 : idx + AW'(1);
            frame_done <= (idx == AW'(NUM_DIGITS - 1));
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= S_GAP;
      endcase
    end
  end

endmodule
